regfile_writeback_arbiter: RTL and testbench
============================================

Name: regfile_writeback_arbiter

Overview:
- Sole driver of the register file write port: RegWrite, WriteReg and WriteData.
- Merges two write sources:
  - in-order pipeline writeback, which never waits;
  - long-latency unit writeback (load/mul/div), valid/ready handshake, buffered in a small FIFO.
- Guarantees one write per cycle, drops writes to $0, and preserves program order: a younger pipeline write to reg R kills older queued writes to R.
- Exports a pending-write mask for the hazard unit.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)
- DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 3, consecutive cycles the FIFO head may be bypassed before pipeline is stalled

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pipe_we  in  1  pipeline writeback request (no handshake)
- pipe_reg  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept; = (count < DEPTH), from registered state only
- lu_reg  in  ADDR_W  long-latency destination register
- lu_data  in  DATA_W  long-latency result
- RegWrite  out  1  register file write enable (registered)
- WriteReg  out  ADDR_W  register file write index (registered)
- WriteData  out  DATA_W  register file write data (registered)
- busy_mask  out  32  bit r set iff a valid FIFO entry targets r (combinational from FIFO state)
- pipe_stall  out  1  upstream must not present pipe_we this cycle
- err  out  1  sticky: pipe_we presented while pipe_stall=1
- count  out  $clog2(DEPTH)+1  valid FIFO entries

Behaviour:
- Reset, async:
  - Outputs: RegWrite=0, WriteReg=0, WriteData=0, busy_mask=0, pipe_stall=0, err=0, count=0, lu_ready=1.
  - Internal: FIFO pointers, entry valid bits and starve_cnt cleared.
  - Reset mid-operation discards all queued writes; no write is issued after rst is released until a new request arrives.
- Push:
  - On lu_valid & lu_ready, the entry {reg, data, valid=1} is written at the tail.
  - lu_reg==0 is accepted and handshaked, but the entry is not stored.
  - No push when full. lu_ready must not depend on lu_valid.
- Per-cycle output selection, in priority order:
  1. pipe_stall=1 and FIFO nonempty: pop head. If pipe_we=1 the pipeline write is dropped and err<=1.
  2. pipe_we=1 and pipe_reg!=0: issue pipeline write.
  3. FIFO nonempty: pop head.
  4. Otherwise: RegWrite<=0.
- Issue latency and output hold:
  - Selected write appears on RegWrite/WriteReg/WriteData the next cycle (latency 1 for pipeline writes).
  - A FIFO push followed by pop gives a minimum 2-cycle latency. There is no bypass.
  - WriteReg/WriteData hold their last values when RegWrite=0.
- Killed entries:
  - A popped head entry whose valid bit is 0 still frees its slot, but RegWrite<=0 that cycle.
  - Implementations may skip consecutive killed entries. One pop per cycle is sufficient.
- Ordering kill: when a pipeline write to R (R!=0) is issued, every valid FIFO entry with reg==R clears its valid bit in the same cycle.
- Same-cycle push and kill: an entry pushed in the same cycle as a pipeline write to the same R is NOT killed. The long-latency result is younger.
- busy_mask:
  - Reflects valid entries only; killed entries clear their bit next cycle.
  - A bit stays set while any other valid entry targets the same reg.
- Duplicate regs in the FIFO: written in FIFO order; the last one wins.
- Simultaneous push and pop: allowed when not full; count unchanged.
- Pointers wrap modulo DEPTH.
- Starvation counter (starve_cnt):
  - Increments when FIFO nonempty and a pipeline write is issued.
  - Cleared on any pop or when FIFO empty.
  - pipe_stall = (starve_cnt == STARVE_LIMIT), asserted for exactly one cycle per starvation event.
- err clears only on reset.

Test Plan:
- Reset check: rst pulse mid-stream with 3 queued entries -> all outputs 0, count=0, lu_ready=1; next cycle with no requests gives RegWrite=0.
- Basic paths:
  - pipe_we, reg 5, data 0xAAAA0001 -> next cycle RegWrite=1, WriteReg=5, WriteData=0xAAAA0001.
  - lu push reg 7, data 0x77 with idle pipe -> write appears 2 cycles after the handshake.
  - pipe_reg=0 -> RegWrite stays 0.
- Full FIFO: push 4 entries (regs 1-4) while pipe_we holds every cycle -> lu_ready=0 at count=4. pipe_stall is asserted after 3 bypassed cycles, head reg 1 pops, lu_ready returns to 1. pipe_we during the stall cycle sets err=1.
- Kill: queue reg 9 (0x1111) behind reg 8, then pipe write reg 9 (0x2222) -> busy_mask[9] clears, reg 9 is written only once with 0x2222, and reg 8 still pops.
- Same-cycle push and kill: same-cycle lu push reg 10 (0xB) and pipe write reg 10 (0xA) -> order is 0xA then 0xB; final reg 10 = 0xB.
- Duplicate regs: push reg 3 twice (0x1 then 0x2) with no pipe writes -> two writes in order; busy_mask[3] stays 1 until the second entry pops.

Source files
------------

// File: rtl/regfile_writeback_arbiter.sv
// Write-port arbiter for the register file: merges in-order pipeline writebacks with
// queued long-latency results, keeping program order and exposing pending-write hazards.
module regfile_writeback_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_we,
    input  logic [ADDR_W-1:0]         pipe_reg,
    input  logic [DATA_W-1:0]         pipe_data,
    input  logic                      lu_valid,
    output logic                      lu_ready,
    input  logic [ADDR_W-1:0]         lu_reg,
    input  logic [DATA_W-1:0]         lu_data,
    output logic                      RegWrite,
    output logic [ADDR_W-1:0]         WriteReg,
    output logic [DATA_W-1:0]         WriteData,
    output logic [31:0]               busy_mask,
    output logic                      pipe_stall,
    output logic                      err,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] reg_q    [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              pipe_ok;
    logic              pipe_issue;
    logic              head_valid;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    logic [31:0]       busy_vec [DEPTH];

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(DEPTH));
    assign lu_ready   = !fifo_full;
    // Writes to $0 are handshaked but never occupy a slot.
    assign push       = lu_valid && !fifo_full && (lu_reg != '0);
    assign pipe_stall = (starve_q == SC_W'(STARVE_LIMIT));
    assign pipe_ok    = pipe_we && (pipe_reg != '0);

    assign head_valid = valid_q[head_q];
    assign head_reg   = reg_q[head_q];
    assign head_data  = data_mem[head_q];

    // The FIFO head wins when the stall is forced or the pipeline has nothing to write.
    always_comb begin
        pop        = 1'b0;
        pipe_issue = 1'b0;
        rw_d       = 1'b0;
        wr_d       = wr_q;
        wd_d       = wd_q;
        if (!fifo_empty && (pipe_stall || !pipe_ok)) begin
            pop = 1'b1;
            if (head_valid) begin
                rw_d = 1'b1;
                wr_d = head_reg;
                wd_d = head_data;
            end
        end else if (pipe_ok) begin
            pipe_issue = 1'b1;
            rw_d       = 1'b1;
            wr_d       = pipe_reg;
            wd_d       = pipe_data;
        end
    end

    always_comb begin
        err_d    = err_q | (pipe_stall & pipe_we);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d   = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push ? tail_q + PTR_W'(1) : tail_q;
        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (pipe_issue && !pipe_stall) begin
            starve_d = starve_q + SC_W'(1);
        end
    end

    // A slot being pushed this cycle is never the target of the same-cycle kill:
    // the long-latency result is the younger write.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [PTR_W-1:0] IDX = PTR_W'(gi);
        logic kill_hit;
        assign kill_hit     = pipe_issue && valid_q[gi] && (reg_q[gi] == pipe_reg);
        assign valid_d[gi]  = (push && tail_q == IDX) ? 1'b1 :
                              ((pop && head_q == IDX) || kill_hit) ? 1'b0 : valid_q[gi];
        assign busy_vec[gi] = valid_q[gi] ? (32'd1 << reg_q[gi]) : 32'd0;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_mask = busy_mask | busy_vec[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[tail_q]    <= lu_reg;
            data_mem[tail_q] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            starve_q <= '0;
            rw_q     <= 1'b0;
            wr_q     <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            starve_q <= starve_d;
            rw_q     <= rw_d;
            wr_q     <= wr_d;
            wd_q     <= wd_d;
            err_q    <= err_d;
        end
    end

    assign RegWrite  = rw_q;
    assign WriteReg  = wr_q;
    assign WriteData = wd_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed vector table with hand-derived expectations,
// an async-reset sequence, then random traffic against a queue-based reference model.
module tb_regfile_writeback_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_we;
    logic [AW-1:0] pipe_reg;
    logic [DW-1:0] pipe_data;
    logic          lu_valid;
    logic          lu_ready;
    logic [AW-1:0] lu_reg;
    logic [DW-1:0] lu_data;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [31:0]   busy_mask;
    logic          pipe_stall;
    logic          err;
    logic [2:0]    count;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .busy_mask(busy_mask), .pipe_stall(pipe_stall), .err(err), .count(count)
    );

    typedef struct {
        bit          pwe;
        logic [4:0]  preg;
        logic [31:0] pdata;
        bit          luv;
        logic [4:0]  lreg;
        logic [31:0] ldata;
        bit          erw;
        logic [4:0]  ewr;
        logic [31:0] ewd;
        logic [2:0]  ecnt;
        bit          erdy;
        bit          estall;
        bit          eerr;
        logic [31:0] ebusy;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          v;
    } ent_t;

    int n_vec  = 0;
    int n_cmp  = 0;
    int n_miss = 0;

    // Reference model: program-ordered queue of pending long-latency writes.
    ent_t        mq[$];
    int          m_starve;
    bit          m_rw;
    bit          m_err;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;

    vec_t tbl[$];

    function automatic vec_t V(input bit pwe, input logic [4:0] preg, input logic [31:0] pdata,
                               input bit luv, input logic [4:0] lreg, input logic [31:0] ldata,
                               input bit erw, input logic [4:0] ewr, input logic [31:0] ewd,
                               input logic [2:0] ecnt, input bit erdy, input bit estall,
                               input bit eerr, input logic [31:0] ebusy);
        vec_t v;
        v.pwe = pwe;   v.preg = preg;   v.pdata = pdata;
        v.luv = luv;   v.lreg = lreg;   v.ldata = ldata;
        v.erw = erw;   v.ewr = ewr;     v.ewd = ewd;
        v.ecnt = ecnt; v.erdy = erdy;   v.estall = estall;
        v.eerr = eerr; v.ebusy = ebusy;
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_starve = 0;
        m_rw     = 1'b0;
        m_err    = 1'b0;
        m_wr     = '0;
        m_wd     = '0;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (mq[i]) if (mq[i].v) b[mq[i].r] = 1'b1;
        return b;
    endfunction

    function automatic void model_step(input vec_t v);
        bit   stall;
        bit   nonempty;
        bit   room;
        bit   pipe_wants;
        ent_t h;
        ent_t e;
        stall      = (m_starve == LIMIT);
        nonempty   = (mq.size() != 0);
        room       = (mq.size() < DEPTH);
        pipe_wants = v.pwe && (v.preg != 0);
        if (stall && v.pwe) m_err = 1'b1;
        m_rw = 1'b0;
        if (nonempty && (stall || !pipe_wants)) begin
            h = mq.pop_front();
            if (h.v) begin
                m_rw = 1'b1;
                m_wr = h.r;
                m_wd = h.d;
            end
            m_starve = 0;
        end else if (pipe_wants) begin
            m_rw = 1'b1;
            m_wr = v.preg;
            m_wd = v.pdata;
            foreach (mq[i]) if (mq[i].r == v.preg) mq[i].v = 1'b0;
            m_starve = nonempty ? m_starve + 1 : 0;
        end else begin
            m_starve = 0;
        end
        if (v.luv && room && v.lreg != 0) begin
            e.r = v.lreg;
            e.d = v.ldata;
            e.v = 1'b1;
            mq.push_back(e);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (vector %0d)", name, act, exp, n_vec);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".RegWrite"},   RegWrite,   0);
        chk({tag, ".WriteReg"},   WriteReg,   0);
        chk({tag, ".WriteData"},  WriteData,  0);
        chk({tag, ".busy_mask"},  busy_mask,  0);
        chk({tag, ".pipe_stall"}, pipe_stall, 0);
        chk({tag, ".err"},        err,        0);
        chk({tag, ".count"},      count,      0);
        chk({tag, ".lu_ready"},   lu_ready,   1);
    endtask

    task automatic drive_step(input vec_t v, input bit use_tbl, input string tag);
        pipe_we   = v.pwe;
        pipe_reg  = v.preg;
        pipe_data = v.pdata;
        lu_valid  = v.luv;
        lu_reg    = v.lreg;
        lu_data   = v.ldata;
        #1;
        chk({tag, ".pre.lu_ready"},   lu_ready,   (mq.size() < DEPTH));
        chk({tag, ".pre.pipe_stall"}, pipe_stall, (m_starve == LIMIT));
        chk({tag, ".pre.busy_mask"},  busy_mask,  model_busy());
        chk({tag, ".pre.count"},      count,      mq.size());
        model_step(v);
        @(posedge clk);
        #1;
        chk({tag, ".RegWrite"},  RegWrite,  m_rw);
        chk({tag, ".WriteReg"},  WriteReg,  m_wr);
        chk({tag, ".WriteData"}, WriteData, m_wd);
        chk({tag, ".err"},       err,       m_err);
        if (use_tbl) begin
            chk({tag, ".tbl.RegWrite"},   RegWrite,   v.erw);
            chk({tag, ".tbl.WriteReg"},   WriteReg,   v.ewr);
            chk({tag, ".tbl.WriteData"},  WriteData,  v.ewd);
            chk({tag, ".tbl.count"},      count,      v.ecnt);
            chk({tag, ".tbl.lu_ready"},   lu_ready,   v.erdy);
            chk({tag, ".tbl.pipe_stall"}, pipe_stall, v.estall);
            chk({tag, ".tbl.err"},        err,        v.eerr);
            chk({tag, ".tbl.busy_mask"},  busy_mask,  v.ebusy);
        end
        n_vec++;
        $display("vec %0d %s: pwe=%0b preg=%0d luv=%0b lreg=%0d -> RegWrite=%0b WriteReg=%0d WriteData=%h count=%0d busy=%h",
                 n_vec, tag, v.pwe, v.preg, v.luv, v.lreg, RegWrite, WriteReg, WriteData, count, busy_mask);
    endtask

    initial begin
        vec_t idle;
        idle = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        // Basic paths
        tbl.push_back(V(1,  5, 'hAAAA0001, 0, 0, 0,      1,  5, 'hAAAA0001, 0, 1, 0, 0, 'h0));
        tbl.push_back(V(1,  0, 'h12345678, 0, 0, 0,      0,  5, 'hAAAA0001, 0, 1, 0, 0, 'h0));
        tbl.push_back(V(0,  0, 0,          1, 7, 'h77,   0,  5, 'hAAAA0001, 1, 1, 0, 0, 'h80));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  7, 'h77,       0, 1, 0, 0, 'h0));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      0,  7, 'h77,       0, 1, 0, 0, 'h0));
        // Fill while the pipeline writes every cycle; forced stall pops reg 1
        tbl.push_back(V(1, 20, 'h200,      1, 1, 'h11,   1, 20, 'h200,      1, 1, 0, 0, 'h2));
        tbl.push_back(V(1, 21, 'h201,      1, 2, 'h22,   1, 21, 'h201,      2, 1, 0, 0, 'h6));
        tbl.push_back(V(1, 22, 'h202,      1, 3, 'h33,   1, 22, 'h202,      3, 1, 0, 0, 'hE));
        tbl.push_back(V(1, 23, 'h203,      1, 4, 'h44,   1, 23, 'h203,      4, 0, 1, 0, 'h1E));
        tbl.push_back(V(1, 24, 'h204,      1, 5, 'h55,   1,  1, 'h11,       3, 1, 0, 1, 'h1C));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  2, 'h22,       2, 1, 0, 1, 'h18));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  3, 'h33,       1, 1, 0, 1, 'h10));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  4, 'h44,       0, 1, 0, 1, 'h0));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      0,  4, 'h44,       0, 1, 0, 1, 'h0));
        // Kill: reg 9 queued behind reg 8, then overwritten by the pipeline
        tbl.push_back(V(1, 30, 'h300,      1, 8, 'h8888, 1, 30, 'h300,      1, 1, 0, 1, 'h100));
        tbl.push_back(V(1, 31, 'h301,      1, 9, 'h1111, 1, 31, 'h301,      2, 1, 0, 1, 'h300));
        tbl.push_back(V(1,  9, 'h2222,     0, 0, 0,      1,  9, 'h2222,     2, 1, 0, 1, 'h100));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  8, 'h8888,     1, 1, 0, 1, 'h0));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      0,  8, 'h8888,     0, 1, 0, 1, 'h0));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      0,  8, 'h8888,     0, 1, 0, 1, 'h0));
        // Same-cycle push and pipeline write to reg 10
        tbl.push_back(V(1, 10, 'hA,        1, 10, 'hB,   1, 10, 'hA,        1, 1, 0, 1, 'h400));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1, 10, 'hB,        0, 1, 0, 1, 'h0));
        // Duplicate reg 3
        tbl.push_back(V(0,  0, 0,          1, 3, 'h1,    0, 10, 'hB,        1, 1, 0, 1, 'h8));
        tbl.push_back(V(0,  0, 0,          1, 3, 'h2,    1,  3, 'h1,        1, 1, 0, 1, 'h8));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      1,  3, 'h2,        0, 1, 0, 1, 'h0));
        tbl.push_back(V(0,  0, 0,          0, 0, 0,      0,  3, 'h2,        0, 1, 0, 1, 'h0));
        // Long-latency write to $0 is accepted but never stored
        tbl.push_back(V(0,  0, 0,          1, 0, 'hDEAD, 0,  3, 'h2,        0, 1, 0, 1, 'h0));
        // Three entries queued behind pipeline writes, ahead of the reset pulse
        tbl.push_back(V(1, 11, 'h11,       1, 12, 'hC,   1, 11, 'h11,       1, 1, 0, 1, 'h1000));
        tbl.push_back(V(1, 11, 'h11,       1, 13, 'hD,   1, 11, 'h11,       2, 1, 0, 1, 'h3000));
        tbl.push_back(V(1, 11, 'h11,       1, 14, 'hE,   1, 11, 'h11,       3, 1, 0, 1, 'h7000));

        rst = 1'b1;
        pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i], 1'b1, "tbl");
        end

        // Asynchronous reset mid-stream with three entries queued
        pipe_we = 1'b0; pipe_reg = '0; pipe_data = '0;
        lu_valid = 1'b0; lu_reg = '0; lu_data = '0;
        chk("pre_rst.count", count, 3);
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_step(idle, 1'b1, "post_rst");
        drive_step(idle, 1'b1, "post_rst");

        // Random traffic; small register range to force collisions and kills
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            bit   stall_now;
            stall_now = (m_starve == LIMIT);
            v = idle;
            v.pwe   = stall_now ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) < 6);
            v.preg  = 5'($urandom_range(0, 7));
            v.pdata = $urandom;
            v.luv   = ($urandom_range(0, 1) == 1);
            v.lreg  = 5'($urandom_range(0, 7));
            v.ldata = $urandom;
            drive_step(v, 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
